// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared definitions for the TLB refill sequencer.
// Holds the address/field widths, the page-table-entry layout, the walk FSM
// state encoding, the TLB side encoding and two small helpers: one that splits
// a raw PTE word into its fields and one that forms a PTE address.
package tlb_refill_ctrl_pkg;

    localparam int VA_W    = 32;
    localparam int PA_W    = 20;
    localparam int PGOFF_W = 12;
    localparam int THR_W   = 2;
    localparam int PTE_W   = 32;
    localparam int VPN_W   = VA_W - PGOFF_W;
    localparam int PPN_W   = PA_W - PGOFF_W;

    // Bit positions inside a raw PTE word
    localparam int PTE_VALID_BIT = 31;
    localparam int PTE_WPRIV_BIT = 30;

    typedef enum logic [2:0] {
        WALK_IDLE  = 3'd0,
        WALK_REQ   = 3'd1,
        WALK_WAIT  = 3'd2,
        WALK_WRITE = 3'd3,
        WALK_FAULT = 3'd4
    } tlb_walk_state_t;

    typedef enum logic {
        TLB_SIDE_I = 1'b0,
        TLB_SIDE_D = 1'b1
    } tlb_side_t;

    typedef struct packed {
        logic             valid;
        logic             wpriv;
        logic [PPN_W-1:0] ppn;
    } tlb_pte_t;

    // Extract valid/wpriv/PPN; PPN bits above PPN_W are dropped.
    function automatic tlb_pte_t pte_unpack(input logic [PTE_W-1:0] raw);
        tlb_pte_t pte;
        pte.valid = raw[PTE_VALID_BIT];
        pte.wpriv = raw[PTE_WPRIV_BIT];
        pte.ppn   = raw[PPN_W-1:0];
        return pte;
    endfunction

    // PTE address = base + VPN*4, wrapping modulo 2^PA_W.
    function automatic logic [PA_W-1:0] pte_addr(input logic [PA_W-1:0] base,
                                                 input logic [VA_W-1:0] va);
        logic [VPN_W+1:0] scaled;
        scaled = {va[VA_W-1:PGOFF_W], 2'b00};
        return base + scaled[PA_W-1:0];
    endfunction

endpackage

// File: rtl/tlb_refill_ctrl_if.sv
// Bus bundle between the refill sequencer and its environment.
// Groups the iTLB/dTLB miss handshakes, the PTE memory read port, the TLB
// write-back strobes and the page-fault report.
// master: the sequencer (drives acks, memory request, TLB writes, faults).
// slave : the environment (drives misses, memory ready/response).
interface tlb_refill_ctrl_if;
    import tlb_refill_ctrl_pkg::*;

    logic             i_miss_valid;
    logic [THR_W-1:0] i_miss_thread;
    logic [VA_W-1:0]  i_miss_va;
    logic             i_miss_ack;

    logic             d_miss_valid;
    logic [THR_W-1:0] d_miss_thread;
    logic [VA_W-1:0]  d_miss_va;
    logic             d_miss_ack;

    logic             mem_req_valid;
    logic [PA_W-1:0]  mem_req_addr;
    logic             mem_req_ready;
    logic             mem_rsp_valid;
    logic [PTE_W-1:0] mem_rsp_data;

    logic             new_tlb_entry_i;
    logic             new_tlb_entry_d;
    logic [THR_W-1:0] new_tlb_thread_id;
    logic [VA_W-1:0]  new_tlb_va;
    logic [PA_W-1:0]  new_tlb_pa;
    logic             new_tlb_wpriv;

    logic             pf_valid;
    logic             pf_side;
    logic [THR_W-1:0] pf_thread;
    logic [VA_W-1:0]  pf_va;

    modport master (
        input  i_miss_valid, i_miss_thread, i_miss_va,
        input  d_miss_valid, d_miss_thread, d_miss_va,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output i_miss_ack, d_miss_ack,
        output mem_req_valid, mem_req_addr,
        output new_tlb_entry_i, new_tlb_entry_d, new_tlb_thread_id,
        output new_tlb_va, new_tlb_pa, new_tlb_wpriv,
        output pf_valid, pf_side, pf_thread, pf_va
    );

    modport slave (
        output i_miss_valid, i_miss_thread, i_miss_va,
        output d_miss_valid, d_miss_thread, d_miss_va,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  i_miss_ack, d_miss_ack,
        input  mem_req_valid, mem_req_addr,
        input  new_tlb_entry_i, new_tlb_entry_d, new_tlb_thread_id,
        input  new_tlb_va, new_tlb_pa, new_tlb_wpriv,
        input  pf_valid, pf_side, pf_thread, pf_va
    );

endinterface

// File: rtl/tlb_refill_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports: clock, reset (sync, active-high); req[0]=iTLB, req[1]=dTLB;
// advance = the current grant was taken; grant = one-hot (combinational).
// After reset the dTLB side is preferred; after every taken grant the
// preference moves to the side that was not granted.
module tlb_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prefer_d_r;

    // Grant selection: preference only matters when both sides request
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = prefer_d_r ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Preference pointer update on every taken grant
    always_ff @(posedge clock) begin
        if (reset) begin
            prefer_d_r <= 1'b1;
        end else if (advance && grant[1]) begin
            prefer_d_r <= 1'b0;
        end else if (advance && grant[0]) begin
            prefer_d_r <= 1'b1;
        end else begin
            prefer_d_r <= prefer_d_r;
        end
    end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB refill sequencer shared by the iTLB and dTLB of one core.
// Arbitrates miss requests, reads one PTE from a single-level page table and
// either writes the translation back to the requesting TLB or reports a
// page fault. One walk in flight; every output comes straight from a flop.
// Ports: clock, reset (sync, active-high); pt_base = page-table base, sampled
// at grant; flush = kill the walk in progress; bus = tlb_refill_ctrl_if.master.
module tlb_refill_ctrl
    import tlb_refill_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [PA_W-1:0]  pt_base,
    input  logic             flush,
    tlb_refill_ctrl_if.master bus
);

    tlb_walk_state_t  state_r, state_s;
    tlb_side_t        side_r, side_s;
    logic [THR_W-1:0] thread_r, thread_s;
    logic [VA_W-1:0]  va_r, va_s;
    logic             kill_r, kill_s;

    logic             i_ack_r, i_ack_s;
    logic             d_ack_r, d_ack_s;
    logic             req_valid_r, req_valid_s;
    logic [PA_W-1:0]  req_addr_r, req_addr_s;
    logic             entry_i_r, entry_i_s;
    logic             entry_d_r, entry_d_s;
    logic [THR_W-1:0] new_thread_r, new_thread_s;
    logic [VA_W-1:0]  new_va_r, new_va_s;
    logic [PA_W-1:0]  new_pa_r, new_pa_s;
    logic             new_wpriv_r, new_wpriv_s;
    logic             pf_valid_r, pf_valid_s;
    logic             pf_side_r, pf_side_s;
    logic [THR_W-1:0] pf_thread_r, pf_thread_s;
    logic [VA_W-1:0]  pf_va_r, pf_va_s;

    logic [1:0]       arb_req_s;
    logic [1:0]       arb_grant_s;
    logic             arb_advance_s;
    tlb_pte_t         pte_s;
    logic             kill_now_s;
    logic [VA_W-1:0]  grant_va_s;
    logic [THR_W-1:0] grant_thread_s;

    assign arb_req_s = {bus.d_miss_valid, bus.i_miss_valid};

    tlb_rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (arb_req_s),
        .advance (arb_advance_s),
        .grant   (arb_grant_s)
    );

    // Next-state and next-output logic of the walk FSM
    always_comb begin
        state_s        = state_r;
        side_s         = side_r;
        thread_s       = thread_r;
        va_s           = va_r;
        kill_s         = kill_r;
        i_ack_s        = 1'b0;
        d_ack_s        = 1'b0;
        req_valid_s    = 1'b0;
        req_addr_s     = req_addr_r;
        entry_i_s      = 1'b0;
        entry_d_s      = 1'b0;
        new_thread_s   = '0;
        new_va_s       = '0;
        new_pa_s       = '0;
        new_wpriv_s    = 1'b0;
        pf_valid_s     = 1'b0;
        pf_side_s      = 1'b0;
        pf_thread_s    = '0;
        pf_va_s        = '0;
        arb_advance_s  = 1'b0;
        pte_s          = pte_unpack(bus.mem_rsp_data);
        // A flush arriving together with the response still counts.
        kill_now_s     = kill_r | flush;
        grant_va_s     = arb_grant_s[1] ? bus.d_miss_va : bus.i_miss_va;
        grant_thread_s = arb_grant_s[1] ? bus.d_miss_thread : bus.i_miss_thread;

        case (state_r)
            WALK_IDLE: begin
                kill_s = 1'b0;
                if (arb_grant_s != 2'b00) begin
                    arb_advance_s = 1'b1;
                    side_s        = arb_grant_s[1] ? TLB_SIDE_D : TLB_SIDE_I;
                    thread_s      = grant_thread_s;
                    va_s          = grant_va_s;
                    req_addr_s    = pte_addr(pt_base, grant_va_s);
                    req_valid_s   = 1'b1;
                    i_ack_s       = arb_grant_s[0];
                    d_ack_s       = arb_grant_s[1];
                    state_s       = WALK_REQ;
                end else begin
                    state_s = WALK_IDLE;
                end
            end
            WALK_REQ: begin
                // The request is never withdrawn, even when killed.
                kill_s = kill_now_s;
                if (bus.mem_req_ready) begin
                    req_valid_s = 1'b0;
                    state_s     = WALK_WAIT;
                end else begin
                    req_valid_s = 1'b1;
                    state_s     = WALK_REQ;
                end
            end
            WALK_WAIT: begin
                kill_s = kill_now_s;
                if (bus.mem_rsp_valid) begin
                    if (pte_s.valid) begin
                        state_s = WALK_WRITE;
                        if (!kill_now_s) begin
                            entry_i_s    = (side_r == TLB_SIDE_I);
                            entry_d_s    = (side_r == TLB_SIDE_D);
                            new_thread_s = thread_r;
                            new_va_s     = va_r;
                            new_pa_s     = {pte_s.ppn, va_r[PGOFF_W-1:0]};
                            new_wpriv_s  = pte_s.wpriv;
                        end else begin
                            entry_i_s = 1'b0;
                        end
                    end else begin
                        state_s = WALK_FAULT;
                        if (!kill_now_s) begin
                            pf_valid_s  = 1'b1;
                            pf_side_s   = side_r;
                            pf_thread_s = thread_r;
                            pf_va_s     = va_r;
                        end else begin
                            pf_valid_s = 1'b0;
                        end
                    end
                end else begin
                    state_s = WALK_WAIT;
                end
            end
            WALK_WRITE, WALK_FAULT: begin
                kill_s  = 1'b0;
                state_s = WALK_IDLE;
            end
            default: begin
                kill_s  = 1'b0;
                state_s = WALK_IDLE;
            end
        endcase
    end

    // State, walk context and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= WALK_IDLE;
            side_r       <= TLB_SIDE_I;
            thread_r     <= '0;
            va_r         <= '0;
            kill_r       <= 1'b0;
            i_ack_r      <= 1'b0;
            d_ack_r      <= 1'b0;
            req_valid_r  <= 1'b0;
            req_addr_r   <= '0;
            entry_i_r    <= 1'b0;
            entry_d_r    <= 1'b0;
            new_thread_r <= '0;
            new_va_r     <= '0;
            new_pa_r     <= '0;
            new_wpriv_r  <= 1'b0;
            pf_valid_r   <= 1'b0;
            pf_side_r    <= 1'b0;
            pf_thread_r  <= '0;
            pf_va_r      <= '0;
        end else begin
            state_r      <= state_s;
            side_r       <= side_s;
            thread_r     <= thread_s;
            va_r         <= va_s;
            kill_r       <= kill_s;
            i_ack_r      <= i_ack_s;
            d_ack_r      <= d_ack_s;
            req_valid_r  <= req_valid_s;
            req_addr_r   <= req_addr_s;
            entry_i_r    <= entry_i_s;
            entry_d_r    <= entry_d_s;
            new_thread_r <= new_thread_s;
            new_va_r     <= new_va_s;
            new_pa_r     <= new_pa_s;
            new_wpriv_r  <= new_wpriv_s;
            pf_valid_r   <= pf_valid_s;
            pf_side_r    <= pf_side_s;
            pf_thread_r  <= pf_thread_s;
            pf_va_r      <= pf_va_s;
        end
    end

    assign bus.i_miss_ack        = i_ack_r;
    assign bus.d_miss_ack        = d_ack_r;
    assign bus.mem_req_valid     = req_valid_r;
    assign bus.mem_req_addr      = req_addr_r;
    assign bus.new_tlb_entry_i   = entry_i_r;
    assign bus.new_tlb_entry_d   = entry_d_r;
    assign bus.new_tlb_thread_id = new_thread_r;
    assign bus.new_tlb_va        = new_va_r;
    assign bus.new_tlb_pa        = new_pa_r;
    assign bus.new_tlb_wpriv     = new_wpriv_r;
    assign bus.pf_valid          = pf_valid_r;
    assign bus.pf_side           = pf_side_r;
    assign bus.pf_thread         = pf_thread_r;
    assign bus.pf_va             = pf_va_r;

endmodule
